// File: rtl/gerador_pulso_pkg.sv
// Shared definitions for the pulse generator: per-channel FSM states and default sizing.
package gerador_pulso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GUARD  = 2'd2
    } estado_t;

    localparam int N_PADRAO     = 2;
    localparam int WIDTH_PADRAO = 8;

endpackage

// File: rtl/gerador_pulso_canal.sv
// One pulse channel: IDLE -> ACTIVE for the latched length -> one GUARD cycle -> IDLE.
module gerador_pulso_canal
    import gerador_pulso_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disparo,
    input  logic [WIDTH-1:0] largura,
    input  logic             modo,
    output logic             saida,
    output logic             ocupado,
    output logic             perdido
);

    estado_t          estado;
    estado_t          estado_prox;
    logic [WIDTH-1:0] contador;
    logic [WIDTH-1:0] contador_prox;
    logic             saida_prox;
    logic             perdido_prox;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= IDLE;
            contador <= '0;
            saida    <= 1'b0;
            ocupado  <= 1'b0;
            perdido  <= 1'b0;
        end else begin
            estado   <= estado_prox;
            contador <= contador_prox;
            saida    <= saida_prox;
            ocupado  <= (estado_prox != IDLE);
            perdido  <= perdido_prox;
        end
    end

    // A retrigger takes priority over expiry, so a reload on the last edge keeps saida high.
    always_comb begin
        estado_prox   = estado;
        contador_prox = contador;
        perdido_prox  = 1'b0;
        case (estado)
            IDLE: begin
                if (disparo && (largura != '0)) begin
                    estado_prox   = ACTIVE;
                    contador_prox = largura;
                end
            end
            ACTIVE: begin
                if (disparo && modo && (largura != '0)) begin
                    contador_prox = largura;
                end else begin
                    perdido_prox = disparo;
                    if (contador <= WIDTH'(1)) begin
                        estado_prox   = GUARD;
                        contador_prox = '0;
                    end else begin
                        contador_prox = contador - WIDTH'(1);
                    end
                end
            end
            GUARD: begin
                perdido_prox = disparo;
                estado_prox  = IDLE;
            end
            default: begin
                estado_prox   = IDLE;
                contador_prox = '0;
            end
        endcase
        saida_prox = (estado_prox == ACTIVE);
    end

endmodule

// File: rtl/gerador_pulso.sv
// N independent pulse channels sharing the length and mode inputs.
module gerador_pulso
    import gerador_pulso_pkg::*;
#(
    parameter int N     = N_PADRAO,
    parameter int WIDTH = WIDTH_PADRAO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     disparo,
    input  logic [WIDTH-1:0] largura,
    input  logic             modo,
    output logic [N-1:0]     saida,
    output logic [N-1:0]     ocupado,
    output logic [N-1:0]     perdido
);

    for (genvar i = 0; i < N; i++) begin : g_canal
        gerador_pulso_canal #(
            .WIDTH(WIDTH)
        ) u_canal (
            .clk    (clk),
            .rst    (rst),
            .disparo(disparo[i]),
            .largura(largura),
            .modo   (modo),
            .saida  (saida[i]),
            .ocupado(ocupado[i]),
            .perdido(perdido[i])
        );
    end

endmodule

// File: tb/tb_gerador_pulso.sv
// Self-checking bench for gerador_pulso: fixed vector table, corner sequences and random traffic
// compared against a timeline model that tracks the edge at which each channel's pulse ends.
module tb_gerador_pulso;

    localparam int N = 2;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] disparo;
    logic [W-1:0] largura;
    logic         modo;
    logic [N-1:0] saida;
    logic [N-1:0] ocupado;
    logic [N-1:0] perdido;

    gerador_pulso #(.N(N), .WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .disparo(disparo),
        .largura(largura),
        .modo   (modo),
        .saida  (saida),
        .ocupado(ocupado),
        .perdido(perdido)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [N-1:0] disparo;
        logic [W-1:0] largura;
        logic         modo;
        logic [N-1:0] saida;
        logic [N-1:0] ocupado;
        logic [N-1:0] perdido;
    } vetor_t;

    int checks   = 0;
    int failures = 0;

    // Model: fim[i] is the edge index at which saida[i] drops; edge fim+1 is the guard edge.
    int           t = 0;
    int           fim [N];
    logic [N-1:0] exp_saida;
    logic [N-1:0] exp_ocupado;
    logic [N-1:0] exp_perdido;

    task automatic check_output(input string nome, input logic [N-1:0] atual, input logic [N-1:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", nome, t, atual, esperado);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) fim[i] = -1000;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] d, input logic [W-1:0] l, input logic m);
        bit ativo;
        bit guarda;
        disparo = d;
        largura = l;
        modo    = m;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            ativo          = (t <= fim[i]);
            guarda         = (t == fim[i] + 1);
            exp_perdido[i] = 1'b0;
            if (d[i]) begin
                if (ativo) begin
                    if (m && l != 0) fim[i] = t + int'(l);
                    else exp_perdido[i] = 1'b1;
                end else if (guarda) begin
                    exp_perdido[i] = 1'b1;
                end else if (l != 0) begin
                    fim[i] = t + int'(l);
                end
            end
            exp_saida[i]   = (t < fim[i]);
            exp_ocupado[i] = (t <= fim[i]);
        end
        check_output("model_saida", saida, exp_saida);
        check_output("model_ocupado", ocupado, exp_ocupado);
        check_output("model_perdido", perdido, exp_perdido);
        t++;
    endtask

    task automatic async_reset_pulse();
        #3 rst = 1'b1;
        #1;
        check_output("rst_saida", saida, '0);
        check_output("rst_ocupado", ocupado, '0);
        check_output("rst_perdido", perdido, '0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    vetor_t tabela [30];
    int     comprimento;

    initial begin
        // Channel 0 basics, guard drop, zero length, non-retrigger drop, retrigger, dual channel.
        tabela[0]  = '{2'b01, 8'd3, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[1]  = '{2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[2]  = '{2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[3]  = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b01, 2'b00};
        tabela[4]  = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        tabela[5]  = '{2'b01, 8'd1, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[6]  = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b01, 2'b00};
        tabela[7]  = '{2'b01, 8'd3, 1'b0, 2'b00, 2'b00, 2'b01};
        tabela[8]  = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        tabela[9]  = '{2'b01, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        tabela[10] = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        tabela[11] = '{2'b01, 8'd5, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[12] = '{2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[13] = '{2'b01, 8'd5, 1'b0, 2'b01, 2'b01, 2'b01};
        tabela[14] = '{2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[15] = '{2'b00, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00};
        tabela[16] = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b01, 2'b00};
        tabela[17] = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        tabela[18] = '{2'b01, 8'd4, 1'b1, 2'b01, 2'b01, 2'b00};
        tabela[19] = '{2'b00, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00};
        tabela[20] = '{2'b01, 8'd4, 1'b1, 2'b01, 2'b01, 2'b00};
        tabela[21] = '{2'b00, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00};
        tabela[22] = '{2'b00, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00};
        tabela[23] = '{2'b00, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00};
        tabela[24] = '{2'b00, 8'd0, 1'b1, 2'b00, 2'b01, 2'b00};
        tabela[25] = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        tabela[26] = '{2'b11, 8'd2, 1'b0, 2'b11, 2'b11, 2'b00};
        tabela[27] = '{2'b00, 8'd0, 1'b0, 2'b11, 2'b11, 2'b00};
        tabela[28] = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b11, 2'b00};
        tabela[29] = '{2'b00, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00};

        model_reset();
        rst     = 1'b1;
        disparo = '0;
        largura = '0;
        modo    = 1'b0;
        #2;
        check_output("reset_async_saida", saida, '0);
        check_output("reset_async_ocupado", ocupado, '0);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_perdido", perdido, '0);
        #2 rst = 1'b0;

        for (int v = 0; v < 30; v++) begin
            apply_stimulus(tabela[v].disparo, tabela[v].largura, tabela[v].modo);
            check_output($sformatf("tab%0d_saida", v), saida, tabela[v].saida);
            check_output($sformatf("tab%0d_ocupado", v), ocupado, tabela[v].ocupado);
            check_output($sformatf("tab%0d_perdido", v), perdido, tabela[v].perdido);
        end

        // Reset in the middle of a long pulse, then an immediate trigger after release.
        apply_stimulus(2'b01, 8'd10, 1'b0);
        repeat (3) apply_stimulus(2'b00, 8'd10, 1'b0);
        check_output("pre_rst_saida", saida, 2'b01);
        async_reset_pulse();
        repeat (3) apply_stimulus(2'b00, 8'd10, 1'b0);
        check_output("post_rst_saida", saida, 2'b00);
        apply_stimulus(2'b10, 8'd2, 1'b0);
        check_output("post_rst_trigger", saida, 2'b10);
        repeat (4) apply_stimulus(2'b00, 8'd0, 1'b0);

        // Maximum length pulse measured by counting high cycles.
        comprimento = 0;
        apply_stimulus(2'b01, 8'd255, 1'b0);
        if (saida[0]) comprimento++;
        for (int c = 0; c < 260; c++) begin
            apply_stimulus(2'b00, 8'd7, 1'b1);
            if (saida[0]) comprimento++;
        end
        checks++;
        if (comprimento != 255) begin
            failures++;
            $display("[TB] FAIL len255 got %0d cycles expected 255", comprimento);
        end

        // Random traffic on both channels, with shared length and mode changing freely.
        for (int r = 0; r < 400; r++) begin
            logic [N-1:0] d;
            for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 9) < 3);
            apply_stimulus(d, W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gerador_pulso.md
GERADOR_PULSO -- requirements
Module: gerador_pulso

Parameters
REQ-001 The block SHALL have parameter N, default 2, meaning the number of independent pulse channels.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the bit width of the pulse-length field and of each channel counter.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port disparo, input, N bits: per-channel one-cycle trigger events, sampled on the rising edge of clk.
REQ-006 The block SHALL have port largura, input, WIDTH bits: pulse length in clk cycles, shared by all channels and latched per channel on acceptance.
REQ-007 The block SHALL have port modo, input, 1 bit: 0 selects non-retriggerable operation; 1 selects retriggerable operation.
REQ-008 The block SHALL have port saida, output, N bits: registered per-channel output pulse levels.
REQ-009 The block SHALL have port ocupado, output, N bits: registered per-channel flag, high while the channel is not IDLE.
REQ-010 The block SHALL have port perdido, output, N bits: registered per-channel one-cycle flag, high when a trigger is dropped.

Function
REQ-011 Each channel SHALL run an independent FSM with states IDLE, ACTIVE and GUARD.
REQ-012 In IDLE, disparo[i]=1 sampled at edge k with largura=L>0 SHALL move the channel to ACTIVE, load the counter with L and drive saida[i]=1 after edge k.
REQ-013 saida[i] SHALL stay high for exactly L clk cycles: high after edges k..k+L-1 and low after edge k+L.
REQ-014 After the last ACTIVE cycle the channel SHALL enter GUARD for exactly 1 cycle with saida[i]=0, then return to IDLE.
REQ-015 A trigger in IDLE with largura=0 SHALL be ignored, with no state change and perdido[i]=0.
REQ-016 A trigger in ACTIVE with modo=0 SHALL be dropped, leave the counter unchanged and set perdido[i]=1 for one cycle.
REQ-017 A trigger in ACTIVE with modo=1 and largura=L>0 SHALL reload the counter with L so that saida[i] stays high for L cycles after the retrigger edge, with no low glitch.
REQ-018 A trigger in ACTIVE with modo=1 and largura=0 SHALL be dropped with perdido[i]=1.
REQ-019 A trigger in GUARD SHALL always be dropped with perdido[i]=1 for one cycle.
REQ-020 A trigger arriving on the same edge where the ACTIVE count expires SHALL be handled as an ACTIVE trigger per REQ-016 and REQ-017.
REQ-021 ocupado[i] SHALL be 1 in ACTIVE and GUARD and 0 in IDLE.
REQ-022 Changes to largura or modo SHALL NOT affect a running pulse except at a retrigger edge.
REQ-023 The counter SHALL be WIDTH bits, unsigned and non-wrapping; L=2^WIDTH-1 SHALL produce a 255-cycle pulse at WIDTH=8.
REQ-024 Channels SHALL be fully independent; simultaneous triggers on several channels SHALL each be handled per their own state.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force saida=0, ocupado=0, perdido=0, all counters to 0 and all FSMs to IDLE.
REQ-026 Asserting reset mid-pulse SHALL abort the pulse with no resume after release.
REQ-027 The first edge after rst deasserts SHALL accept triggers normally.

Structure
REQ-028 A shared package gerador_pulso_pkg SHALL hold the state encodings (IDLE, ACTIVE, GUARD) and the default N and WIDTH constants.
REQ-029 Per-channel logic SHALL be one sub-module, gerador_pulso_canal, instantiated N times by a generate loop.

Verification
REQ-030 The bench SHALL check: largura=3, modo=0, disparo[0] one cycle -> saida[0] high 3 cycles, ocupado[0] high 4 cycles, perdido=0.
REQ-031 The bench SHALL check: largura=5, modo=0, second disparo[0] 2 cycles after the first -> perdido[0] pulses once, saida[0] still exactly 5 cycles.
REQ-032 The bench SHALL check: largura=4, modo=1, retrigger 2 cycles in -> saida[0] high 6 contiguous cycles.
REQ-033 The bench SHALL check: trigger during GUARD -> perdido=1 for one cycle, no pulse; largura=0 trigger in IDLE -> no response.
REQ-034 The bench SHALL check: largura=10, rst pulsed mid-pulse between clk edges -> saida and ocupado drop at once and stay low until the next trigger.
REQ-035 The bench SHALL check: disparo=2'b11 simultaneously, largura=2 -> both channels pulse identically; largura=255 -> a 255-cycle pulse.
